ssd_scan_counter: RTL and testbench

//  Parametrised N-digit BCD up/down counter with a time-multiplexed seven-segment

---
 rtl/ssd_pkg.sv | 41 ++++
 rtl/bcd_digit_cell.sv | 45 ++++
 rtl/ssd_scan_counter.sv | 155 +++++++++++++++
 tb/tb_ssd_scan_counter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared constants and helpers for the seven-segment scan counter.
//   SEG_0..SEG_9 : active-low {a,b,c,d,e,f,g,dp} patterns, bit 7 = a,
//                  decimal point always off (1)
//   SEG_BLANK    : all segments off
//   seg_of()     : BCD digit -> segment pattern (non-BCD codes give blank)
// ---------------------------------------------------------------------------
package ssd_pkg;

   localparam logic [7:0] SEG_0     = 8'h03;
   localparam logic [7:0] SEG_1     = 8'h9F;
   localparam logic [7:0] SEG_2     = 8'h25;
   localparam logic [7:0] SEG_3     = 8'h0D;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h49;
   localparam logic [7:0] SEG_6     = 8'h41;
   localparam logic [7:0] SEG_7     = 8'h1F;
   localparam logic [7:0] SEG_8     = 8'h01;
   localparam logic [7:0] SEG_9     = 8'h09;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [7:0] seg_of(input logic [3:0] bcd4);
      logic [7:0] pat;
      case (bcd4)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// ---------------------------------------------------------------------------
// bcd_digit_cell
// One registered BCD digit of a ripple up/down counter.
//   clk, rst   : clock, synchronous active-high reset (digit -> 0)
//   load       : load load_digit (codes above 9 are clamped to 9)
//   load_digit : 4-bit value to load
//   inc, dec   : global count-up / count-down strobes (mutually exclusive)
//   cin, bin   : carry / borrow in from the next lower digit (1 for digit 0)
//   digit      : current digit value
//   cout, bout : carry / borrow out; high when this and all lower digits
//                sit at 9 (carry) or 0 (borrow) and cin/bin is high
// ---------------------------------------------------------------------------
module bcd_digit_cell (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_digit,
   input  logic       inc,
   input  logic       dec,
   input  logic       cin,
   input  logic       bin,
   output logic [3:0] digit,
   output logic       cout,
   output logic       bout
);

   logic [3:0] r_digit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_digit <= 4'd0;
      end else if (load) begin
         r_digit <= (load_digit > 4'd9) ? 4'd9 : load_digit;
      end else if (inc && cin) begin
         r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
      end else if (dec && bin) begin
         r_digit <= (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
      end
   end

   assign digit = r_digit;
   assign cout  = cin & (r_digit == 4'd9);
   assign bout  = bin & (r_digit == 4'd0);

endmodule

// File: rtl/ssd_scan_counter.sv
// ---------------------------------------------------------------------------
// ssd_scan_counter
// N-digit BCD up/down counter with a built-in count prescaler and a
// time-multiplexed seven-segment scan driver.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   en       : count enable (gates the prescaler and counting)
//   up       : 1 = count up, 0 = count down
//   load     : load load_val (has priority over a coincident tick)
//   load_val : BCD load value, digit 0 in bits [3:0]
//   bcd      : current count (BCD)
//   wrap     : one-cycle pulse when the count wraps 9..9->0..0 or 0..0->9..9
//   segs     : active-low {a,b,c,d,e,f,g,dp}
//   ssd_ctl  : active-low one-hot digit enables
// ---------------------------------------------------------------------------
module ssd_scan_counter
   import ssd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50000000,
   parameter int SCAN_DIV = 100000,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  wrap,
   output logic [7:0]            segs,
   output logic [DIGITS-1:0]     ssd_ctl
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   // ---------------- count prescaler ----------------
   logic [PW-1:0] r_presc;
   logic          w_tick;

   assign w_tick = en & (r_presc == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
      end else if (load) begin
         r_presc <= '0;
      end else if (en) begin
         r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
      end
   end

   // ---------------- digit chain ----------------
   // A load suppresses the step strobes, so a tick coinciding with a load
   // is simply lost.
   logic                w_inc;
   logic                w_dec;
   logic [DIGITS:0]     w_carry;
   logic [DIGITS:0]     w_borrow;
   logic [4*DIGITS-1:0] w_bcd;
   logic                r_wrap;

   assign w_inc       = w_tick & up & ~load;
   assign w_dec       = w_tick & ~up & ~load;
   assign w_carry[0]  = 1'b1;
   assign w_borrow[0] = 1'b1;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_cell u_cell (
         .clk        (clk),
         .rst        (rst),
         .load       (load),
         .load_digit (load_val[4*gi +: 4]),
         .inc        (w_inc),
         .dec        (w_dec),
         .cin        (w_carry[gi]),
         .bin        (w_borrow[gi]),
         .digit      (w_bcd[4*gi +: 4]),
         .cout       (w_carry[gi+1]),
         .bout       (w_borrow[gi+1])
      );
   end

   // The top carry/borrow is high only when every digit is 9 / 0, which is
   // exactly the wrap condition for the step being taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= (w_inc & w_carry[DIGITS]) | (w_dec & w_borrow[DIGITS]);
      end
   end

   assign bcd  = w_bcd;
   assign wrap = r_wrap;

   // ---------------- leading-zero blanking ----------------
   // w_hz[k] is high when digits k..DIGITS-1 are all zero.
   logic [DIGITS:1] w_hz;
   logic [7:0]      w_pat [DIGITS];

   assign w_hz[DIGITS] = 1'b1;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pat
      if (gi == 0) begin : g_lsd
         assign w_pat[gi] = seg_of(w_bcd[3:0]);
      end else begin : g_upper
         assign w_hz[gi] = w_hz[gi+1] & (w_bcd[4*gi +: 4] == 4'd0);
         assign w_pat[gi] = ((BLANK_LZ != 0) && w_hz[gi]) ? SEG_BLANK
                                                          : seg_of(w_bcd[4*gi +: 4]);
      end
   end

   // ---------------- scan driver ----------------
   logic [SW-1:0]     r_scan;
   logic [IW-1:0]     r_idx;
   logic [DIGITS-1:0] r_ctl;
   logic [7:0]        r_segs;
   logic [DIGITS-1:0] w_sel;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
      assign w_sel[gi] = (r_idx == IW'(gi));
   end

   // Enable and pattern are both registered from the same index, so they
   // always switch together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan <= '0;
         r_idx  <= '0;
         r_ctl  <= '1;
         r_segs <= SEG_BLANK;
      end else begin
         r_ctl  <= ~w_sel;
         r_segs <= w_pat[r_idx];
         if (r_scan == SCAN_LAST) begin
            r_scan <= '0;
            r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
         end else begin
            r_scan <= r_scan + SW'(1);
         end
      end
   end

   assign ssd_ctl = r_ctl;
   assign segs    = r_segs;

endmodule

// File: tb/tb_ssd_scan_counter.sv
module tb_ssd_scan_counter;

   localparam int DIGITS   = 4;
   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;
   localparam int BLANK_LZ = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        up;
   logic        load;
   logic [15:0] load_val;
   logic [15:0] bcd;
   logic        wrap;
   logic [7:0]  segs;
   logic [3:0]  ssd_ctl;

   ssd_scan_counter #(
      .DIGITS   (DIGITS),
      .TICK_DIV (TICK_DIV),
      .SCAN_DIV (SCAN_DIV),
      .BLANK_LZ (BLANK_LZ)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .bcd      (bcd),
      .wrap     (wrap),
      .segs     (segs),
      .ssd_ctl  (ssd_ctl)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- behavioural reference ----------------
   // Count kept as a plain integer 0..9999; digits derived arithmetically.
   logic [7:0] pat_tbl [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
   int         m_val, m_presc, m_scan, m_idx;
   logic       m_wrap;
   logic [3:0] m_ctl;
   logic [7:0] m_segs;

   function automatic int pow10(input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r = '0;
      for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
      return r;
   endfunction

   function automatic int load_value(input logic [15:0] lv);
      int v = 0;
      int nib;
      for (int k = 0; k < DIGITS; k++) begin
         nib = int'(lv[4*k +: 4]);
         if (nib > 9) nib = 9;
         v = v + nib * pow10(k);
      end
      return v;
   endfunction

   task automatic model_step();
      int  top;
      bit  tick;
      top = pow10(DIGITS);
      if (rst) begin
         m_val = 0; m_presc = 0; m_scan = 0; m_idx = 0;
         m_wrap = 1'b0; m_ctl = 4'hF; m_segs = 8'hFF;
      end else begin
         m_ctl = ~(4'b0001 << m_idx);
         if (m_idx > 0 && m_val < pow10(m_idx)) m_segs = 8'hFF;
         else m_segs = pat_tbl[(m_val / pow10(m_idx)) % 10];
         tick = en && (m_presc == TICK_DIV - 1);
         if (load) begin
            m_val = load_value(load_val); m_wrap = 1'b0; m_presc = 0;
         end else begin
            if (tick && up) begin
               m_wrap = (m_val == top - 1); m_val = (m_val + 1) % top;
            end else if (tick) begin
               m_wrap = (m_val == 0); m_val = (m_val + top - 1) % top;
            end else begin
               m_wrap = 1'b0;
            end
            if (en) m_presc = (m_presc + 1) % TICK_DIV;
         end
         if (m_scan == SCAN_DIV - 1) begin
            m_scan = 0; m_idx = (m_idx + 1) % DIGITS;
         end else begin
            m_scan = m_scan + 1;
         end
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the edge.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_vs_model(input string tag);
      n_tests++;
      if ({bcd, wrap, ssd_ctl, segs} !== {to_bcd(m_val), m_wrap, m_ctl, m_segs}) begin
         n_fail++;
         $display("FAIL %s: bcd=%h wrap=%b ctl=%b segs=%h, expected bcd=%h wrap=%b ctl=%b segs=%h",
                  tag, bcd, wrap, ssd_ctl, segs, to_bcd(m_val), m_wrap, m_ctl, m_segs);
      end
   endtask

   task automatic mstep(input string tag);
      step();
      check_vs_model(tag);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst, en, up, load;
      logic [15:0] lv;
      logic [15:0] e_bcd;
      logic        e_wrap;
      logic [3:0]  e_ctl;
      logic [7:0]  e_segs;
   } vec_t;

   vec_t tbl [18];

   initial begin
      bit found;

      rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;

      //            rst en up ld  lv        bcd       wr ctl      segs
      tbl[0]  = '{1'b1,0,0,0, 16'h0000, 16'h0000, 0, 4'b1111, 8'hFF};
      tbl[1]  = '{1'b1,0,0,0, 16'h0000, 16'h0000, 0, 4'b1111, 8'hFF};
      tbl[2]  = '{1'b0,0,0,0, 16'h0000, 16'h0000, 0, 4'b1110, 8'h03};
      tbl[3]  = '{1'b0,0,0,0, 16'h0000, 16'h0000, 0, 4'b1110, 8'h03};
      tbl[4]  = '{1'b0,0,0,0, 16'h0000, 16'h0000, 0, 4'b1101, 8'hFF};
      tbl[5]  = '{1'b0,0,0,0, 16'h0000, 16'h0000, 0, 4'b1101, 8'hFF};
      tbl[6]  = '{1'b0,0,0,0, 16'h0000, 16'h0000, 0, 4'b1011, 8'hFF};
      tbl[7]  = '{1'b0,0,0,0, 16'h0000, 16'h0000, 0, 4'b1011, 8'hFF};
      tbl[8]  = '{1'b0,0,0,0, 16'h0000, 16'h0000, 0, 4'b0111, 8'hFF};
      tbl[9]  = '{1'b0,0,0,0, 16'h0000, 16'h0000, 0, 4'b0111, 8'hFF};
      tbl[10] = '{1'b0,0,0,1, 16'h0A05, 16'h0905, 0, 4'b1110, 8'h03};
      tbl[11] = '{1'b0,0,0,0, 16'h0000, 16'h0905, 0, 4'b1110, 8'h49};
      tbl[12] = '{1'b0,0,0,0, 16'h0000, 16'h0905, 0, 4'b1101, 8'h03};
      tbl[13] = '{1'b0,0,0,0, 16'h0000, 16'h0905, 0, 4'b1101, 8'h03};
      tbl[14] = '{1'b0,0,0,0, 16'h0000, 16'h0905, 0, 4'b1011, 8'h09};
      tbl[15] = '{1'b0,0,0,0, 16'h0000, 16'h0905, 0, 4'b1011, 8'h09};
      tbl[16] = '{1'b0,0,0,0, 16'h0000, 16'h0905, 0, 4'b0111, 8'hFF};
      tbl[17] = '{1'b0,0,0,0, 16'h0000, 16'h0905, 0, 4'b0111, 8'hFF};

      // Reset, scan start-up with blanking, then clamped load.
      for (int i = 0; i < 18; i++) begin
         rst = tbl[i].rst; en = tbl[i].en; up = tbl[i].up;
         load = tbl[i].load; load_val = tbl[i].lv;
         step();
         $display("[TB] vec %0d: bcd=%h wrap=%b ctl=%b segs=%h", i, bcd, wrap, ssd_ctl, segs);
         n_tests++;
         if ({bcd, wrap, ssd_ctl, segs} !== {tbl[i].e_bcd, tbl[i].e_wrap, tbl[i].e_ctl, tbl[i].e_segs}) begin
            n_fail++;
            $display("FAIL vec%0d: bcd=%h wrap=%b ctl=%b segs=%h, expected bcd=%h wrap=%b ctl=%b segs=%h",
                     i, bcd, wrap, ssd_ctl, segs, tbl[i].e_bcd, tbl[i].e_wrap, tbl[i].e_ctl, tbl[i].e_segs);
         end
      end
      load = 1'b0;

      // Count up through 9999 -> 0000.
      load = 1'b1; load_val = 16'h9998; en = 1'b0; mstep("s2.load");
      load = 1'b0; en = 1'b1; up = 1'b1;
      repeat (3) mstep("s2.run");
      check("s2.hold_9998", 32'(bcd), 32'h9998);
      mstep("s2.run");
      check("s2.bcd_9999", 32'(bcd), 32'h9999);
      check("s2.no_wrap", 32'(wrap), 32'h0);
      repeat (3) mstep("s2.run");
      check("s2.hold_9999", 32'(bcd), 32'h9999);
      mstep("s2.run");
      check("s2.bcd_0000", 32'(bcd), 32'h0000);
      check("s2.wrap_up", 32'(wrap), 32'h1);
      mstep("s2.run");
      check("s2.wrap_one_cycle", 32'(wrap), 32'h0);
      $display("[TB] scenario up-wrap done: bcd=%h", bcd);

      // Count down through 0000 -> 9999, all digits visible.
      load = 1'b1; load_val = 16'h0000; en = 1'b0; mstep("s3.load");
      load = 1'b0; en = 1'b1; up = 1'b0;
      repeat (3) mstep("s3.run");
      check("s3.hold_0000", 32'(bcd), 32'h0000);
      mstep("s3.run");
      check("s3.bcd_9999", 32'(bcd), 32'h9999);
      check("s3.wrap_down", 32'(wrap), 32'h1);
      en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mstep("s3.scan");
         check("s3.unblanked", 32'(segs), 32'h09);
      end
      $display("[TB] scenario down-wrap done: bcd=%h", bcd);

      // Load coinciding with a tick wins; prescaler restarts.
      en = 1'b1; up = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (m_presc == TICK_DIV - 1) found = 1'b1;
         else mstep("s5.align");
      end
      check("s5.align_found", 32'(found), 32'h1);
      load = 1'b1; load_val = 16'h0042; mstep("s5.load");
      check("s5.load_wins", 32'(bcd), 32'h0042);
      check("s5.no_wrap", 32'(wrap), 32'h0);
      load = 1'b0;
      repeat (3) mstep("s5.run");
      check("s5.hold_0042", 32'(bcd), 32'h0042);
      mstep("s5.run");
      check("s5.inc_0043", 32'(bcd), 32'h0043);
      $display("[TB] scenario load-on-tick done: bcd=%h", bcd);

      // Reset in the middle of a scan.
      en = 1'b0; load = 1'b1; load_val = 16'h1234; mstep("s6.load");
      load = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 16 && !found; i++) begin
         if (ssd_ctl == 4'b1011) found = 1'b1;
         else mstep("s6.seek");
      end
      check("s6.digit2_seen", 32'(found), 32'h1);
      check("s6.bcd_before", 32'(bcd), 32'h1234);
      rst = 1'b1; mstep("s6.rst");
      check("s6.rst_bcd", 32'(bcd), 32'h0000);
      check("s6.rst_ctl", 32'(ssd_ctl), 32'hF);
      check("s6.rst_segs", 32'(segs), 32'hFF);
      rst = 1'b0; mstep("s6.rel");
      check("s6.first_ctl", 32'(ssd_ctl), 32'hE);
      check("s6.first_segs", 32'(segs), 32'h03);
      mstep("s6.rel");
      mstep("s6.rel");
      check("s6.second_ctl", 32'(ssd_ctl), 32'hD);
      check("s6.second_segs", 32'(segs), 32'hFF);
      $display("[TB] scenario mid-reset done");

      // Randomised run against the reference.
      for (int i = 0; i < 1500; i++) begin
         rst  = ($urandom_range(0, 199) == 0);
         load = ($urandom_range(0, 24) == 0);
         en   = ($urandom_range(0, 3) != 0);
         up   = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0:       load_val = 16'h9998;
            1:       load_val = 16'h0001;
            default: load_val = 16'($urandom);
         endcase
         if (rst || load)
            $display("[TB] rand %0d: rst=%b load=%b load_val=%h", i, rst, load, load_val);
         mstep("rand");
      end
      rst = 1'b0; load = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
